pc_gen: RTL

- Parametrised next-PC generator feeding the fetch stage.
- Holds the architectural fetch PC and issues fetch requests over a valid/ready handshake.
- Merges sequential advance, execute-stage redirects (branch/jump) and trap/CLINT redirects with fixed priority.
- Buffers a redirect that arrives while a request is stalled, and supports halt/resume with a fetch counter.

---
 rtl/pc_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Next-PC generator: holds the fetch PC, issues fetch requests over valid/ready,
// and merges sequential advance, execute redirects and trap redirects.
module pc_gen #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = 'h8000_0000,
    parameter int              INST_BYTES = 4,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_valid_o,
    input  logic             fetch_ready_i,
    output logic [XLEN-1:0]  fetch_pc_o,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_pc_i,
    input  logic             halt_i,
    output logic             redirect_taken_o,
    output logic             misalign_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is offered while fetch_valid_o=1 and completes (fire)
    // in a cycle where fetch_ready_i=1. Once offered and not accepted, the
    // request (fetch_valid_o and fetch_pc_o) holds unchanged until it fires.

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q;
    logic              hold_q;
    logic              pend_valid_q;
    logic              pend_trap_q;
    logic [XLEN-1:0]   pend_pc_q;
    logic              taken_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              valid;
    logic              fire;
    logic              held;

    logic              in_redir;
    logic              in_valid;
    logic [XLEN-1:0]   in_raw;
    logic [XLEN-1:0]   in_pc;
    logic              in_mis;
    logic              new_wins;
    logic              sel_valid;
    logic [XLEN-1:0]   sel_pc;

    always_comb begin
        valid = 1'b0;
        case (state_q)
            S_BOOT:  valid = 1'b0;
            S_RUN:   valid = hold_q | ~stall_i;
            S_DRAIN: valid = 1'b1;
            S_HALT:  valid = 1'b0;
            default: valid = 1'b0;
        endcase
    end

    assign fire = valid & fetch_ready_i;
    assign held = valid & ~fetch_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN: begin
                if (halt_i) state_d = held ? S_DRAIN : S_HALT;
            end
            S_DRAIN: begin
                if (fire) state_d = S_HALT;
            end
            S_HALT: begin
                if (trap_valid_i) state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Trap beats redirect; a new redirect may not displace a buffered trap.
    assign in_redir  = redirect_valid_i & (state_q != S_HALT);
    assign in_valid  = trap_valid_i | in_redir;
    assign in_raw    = trap_valid_i ? trap_pc_i : redirect_pc_i;
    assign in_pc     = in_raw & ALIGN_MASK;
    assign in_mis    = |(in_raw & ~ALIGN_MASK);
    assign new_wins  = in_valid & (trap_valid_i | ~(pend_valid_q & pend_trap_q));
    assign sel_valid = new_wins | pend_valid_q;
    assign sel_pc    = new_wins ? in_pc : pend_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            hold_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_pc_q    <= '0;
            taken_q      <= 1'b0;
            misalign_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= held;
            taken_q    <= 1'b0;
            misalign_q <= new_wins & in_mis;
            if (fire) cnt_q <= cnt_q + CNT_W'(1);
            if (held) begin
                // Request is frozen; park the winning target until it fires.
                if (new_wins) begin
                    pend_valid_q <= 1'b1;
                    pend_trap_q  <= trap_valid_i;
                    pend_pc_q    <= in_pc;
                end
            end else begin
                pend_valid_q <= 1'b0;
                pend_trap_q  <= 1'b0;
                if (sel_valid) begin
                    pc_q    <= sel_pc;
                    taken_q <= 1'b1;
                end else if (fire) begin
                    pc_q <= pc_q + INC;
                end
            end
        end
    end

    assign fetch_valid_o    = valid;
    assign fetch_pc_o       = pc_q;
    assign redirect_taken_o = taken_q;
    assign misalign_o       = misalign_q;
    assign halted_o         = (state_q == S_HALT);
    assign fetch_cnt_o      = cnt_q;
    assign dbg_state        = state_q;

endmodule
